// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send clock inhibit, start bit, d0..d7 LSB first,
// odd parity, stop bit, then the device acknowledge sampled on the 11th device clock fall.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_ack,
    output logic       tx_err
);
    localparam int CNT_W = $clog2(INHIBIT_CYCLES);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    // The device's 11th fall both ends the stop bit and carries the ack, so STOP samples it.
    typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP} state_t;

    state_t                state, state_next;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_q, filt_d, fall;
    logic [8:0]            sr;
    logic [CNT_W-1:0]      cnt;
    logic [3:0]            n;
    logic [TMR_W-1:0]      timer;
    logic                  timeout;
    logic                  drive_c, drive_d;

    // NOTE: every path assigns filt_d after a default first line, so no latch is inferred.
    always_comb begin
        filt_d = filt_q;
        if (&filt_sr)
            filt_d = 1'b1;
        else if (~|filt_sr)
            filt_d = 1'b0;
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_sr <= '1;
            filt_q  <= 1'b1;
            fall    <= 1'b0;
        end else begin
            filt_sr <= {ps2c, filt_sr[FILTER_LEN-1:1]};
            filt_q  <= filt_d;
            fall    <= filt_q & ~filt_d;
        end
    end

    assign timeout = (timer == TMR_W'(TIMEOUT_CYCLES - 1)) && !fall;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (wr_ps2) state_next = RTS;
            RTS:   if (cnt == '0) state_next = START;
            START: if (timeout) state_next = IDLE;
                   else if (fall) state_next = DATA;
            DATA:  if (timeout) state_next = IDLE;
                   else if (fall && n == 4'd0) state_next = STOP;
            STOP:  if (timeout || fall) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_idle = (state == IDLE);
        drive_c = (state == RTS);
        drive_d = (state == START) || (state == DATA && !sr[0]);
    end

    assign ps2c = drive_c ? 1'b0 : 1'bz;
    assign ps2d = drive_d ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr           <= '0;
            cnt          <= '0;
            n            <= 4'd0;
            timer        <= '0;
            tx_done_tick <= 1'b0;
            tx_ack       <= 1'b0;
            tx_err       <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (wr_ps2) begin
                        sr  <= {~^din, din};
                        cnt <= CNT_W'(INHIBIT_CYCLES - 1);
                    end
                end
                RTS:   if (cnt != '0) cnt <= cnt - CNT_W'(1);
                START: if (fall) n <= 4'd8;
                DATA: begin
                    if (fall && n != 4'd0) begin
                        sr <= {1'b1, sr[8:1]};
                        n  <= n - 4'd1;
                    end
                end
                STOP: begin
                    if (fall) begin
                        tx_ack       <= ~ps2d;
                        tx_err       <= 1'b0;
                        tx_done_tick <= 1'b1;
                    end
                end
                default: ;
            endcase
            // The watchdog covers every state in which the device owns the clock.
            if (state == START || state == DATA || state == STOP) begin
                if (fall)
                    timer <= '0;
                else
                    timer <= timer + TMR_W'(1);
                if (timeout) begin
                    tx_err       <= 1'b1;
                    tx_ack       <= 1'b0;
                    tx_done_tick <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: a PS/2 device model clocks frames out of the DUT while a
// per-cycle compare process checks line ownership, busy/done timing and held ack/err flags.
module tb_ps2_tx;
    localparam int INH  = 16;
    localparam int FLT  = 4;
    localparam int TMO  = 200;
    localparam int HALF = 20;

    typedef enum int {M_IDLE, M_BUSY, M_END} mph_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    wire        ps2c, ps2d;
    logic       tx_idle, tx_done_tick, tx_ack, tx_err;

    logic dev_c_low = 1'b0, dev_d_low = 1'b0, glitch_low = 1'b0;
    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = (dev_c_low | glitch_low) ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;

    int checks = 0, errors = 0, cyc = 0;

    // Written by the stimulus process only.
    int   end_req_cnt = 0, end_lo = 0, end_hi = 0;
    logic exp_ack = 1'b0, exp_err = 1'b0;
    // Written by the compare process only.
    mph_t m_phase = M_IDLE;
    int   end_seen = 0, inh_left = 0;
    logic hold_ack = 1'b0, hold_err = 1'b0;

    ps2_tx #(.INHIBIT_CYCLES(INH), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din), .ps2c(ps2c), .ps2d(ps2d),
        .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .tx_ack(tx_ack), .tx_err(tx_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Expected on-wire frame {stop, parity, d7..d0, start}; parity makes the total count of ones odd.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0), d, 1'b0};
    endfunction

    always @(negedge clk) begin : compare
        mph_t ph, nx;
        ph = (end_req_cnt != end_seen) ? M_END : m_phase;
        nx = ph;
        if (cyc > 0) begin
            check("ps2c_line", ps2c, !((inh_left > 0) || dev_c_low || glitch_low));
            if (!tx_done_tick) begin
                check("ack_hold", tx_ack, hold_ack);
                check("err_hold", tx_err, hold_err);
            end
            case (ph)
                M_IDLE: begin
                    check("idle_when_idle", tx_idle, 1);
                    check("no_done_idle", tx_done_tick, 0);
                    check("ps2d_released", ps2d, !dev_d_low);
                end
                M_BUSY: begin
                    check("busy_not_idle", tx_idle, 0);
                    check("no_done_busy", tx_done_tick, 0);
                end
                default: begin
                    if (tx_done_tick) begin
                        check("done_window", (cyc >= end_lo) && (cyc <= end_hi), 1);
                        check("done_ack", tx_ack, exp_ack);
                        check("done_err", tx_err, exp_err);
                        check("idle_with_done", tx_idle, 1);
                        hold_ack <= exp_ack;
                        hold_err <= exp_err;
                        nx = M_IDLE;
                    end else begin
                        check("end_not_idle", tx_idle, 0);
                        if (cyc > end_hi) begin
                            check("done_timeout", 0, 1);
                            nx = M_IDLE;
                        end
                    end
                end
            endcase
        end
        // Predict the next edge from the inputs it will sample.
        if (reset) begin
            nx = M_IDLE;
            inh_left <= 0;
            hold_ack <= 1'b0;
            hold_err <= 1'b0;
        end else if (nx == M_IDLE && wr_ps2) begin
            nx = M_BUSY;
            inh_left <= INH;
        end else if (inh_left > 0) begin
            inh_left <= inh_left - 1;
        end
        m_phase  <= nx;
        end_seen <= end_req_cnt;
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        wr_ps2 = 1'b1;
        din    = d;
        tick(1);
        wr_ps2 = 1'b0;
        din    = 8'($urandom);
    endtask

    // mode: 0 ack, 1 no ack, 2 stall then expect timeout, 3 stall with no expectation.
    task automatic dev_frame(input int mode, input int nfalls, input bit glitch, input bit busy,
                             output logic [10:0] bits);
        bit ok;
        int fall_cyc;
        bits = '0;
        fall_cyc = cyc;
        ok = (ps2c === 1'b0);
        check("rts_low", ok, 1);
        if (!ok) return;
        ok = 0;
        for (int t = 0; t < INH + 4 && !ok; t++) begin
            tick(1);
            ok = (ps2c === 1'b1);
        end
        check("rts_release", ok, 1);
        if (!ok) return;
        bits[0] = ps2d;
        tick(HALF);
        for (int k = 1; k <= nfalls; k++) begin
            dev_c_low = 1'b1;
            fall_cyc  = cyc;
            if (k == 11 && mode < 2) begin
                end_lo  = cyc + 1;
                end_hi  = cyc + FLT + 8;
                exp_ack = (mode == 0);
                exp_err = 1'b0;
                end_req_cnt++;
            end
            if (busy && k == 4) begin
                wr_ps2 = 1'b1;
                din    = ~din;
                tick(1);
                wr_ps2 = 1'b0;
                tick(HALF - 1);
            end else begin
                tick(HALF);
            end
            if (k <= 10) bits[k] = ps2d;
            if (k == 10 && mode == 0) dev_d_low = 1'b1;
            dev_c_low = 1'b0;
            if (glitch && k >= 2 && k <= 4) begin
                tick(5);
                glitch_low = 1'b1;
                tick(3);
                glitch_low = 1'b0;
                tick(HALF - 8);
            end else begin
                tick(HALF);
            end
        end
        dev_d_low = 1'b0;
        if (mode == 2) begin
            end_lo  = fall_cyc + TMO;
            end_hi  = fall_cyc + TMO + FLT + 8;
            exp_ack = 1'b0;
            exp_err = 1'b1;
            end_req_cnt++;
        end
        if (mode < 3) begin
            ok = 0;
            for (int t = 0; t < TMO + 100 && !ok; t++) begin
                tick(1);
                ok = (m_phase == M_IDLE);
            end
            check("frame_end", ok, 1);
        end
    endtask

    task automatic frame(input logic [7:0] d, input int mode, input bit glitch, input bit busy,
                         output logic [10:0] bits);
        send(d);
        dev_frame(mode, 11, glitch, busy, bits);
        check($sformatf("bits_%02h", d), bits, frame_of(d));
    endtask

    initial begin : stim
        logic [10:0] bits;
        logic [7:0]  d;
        tick(3);
        reset = 1'b0;
        check("rst_idle", tx_idle, 1);
        check("rst_done", tx_done_tick, 0);
        check("rst_ack", tx_ack, 0);
        check("rst_err", tx_err, 0);
        check("rst_ps2c", ps2c, 1);
        check("rst_ps2d", ps2d, 1);
        tick(2);

        frame(8'hED, 0, 1'b0, 1'b0, bits);
        check("ed_literal", bits, 11'b1_1_11101101_0);
        check("ed_ack", tx_ack, 1);
        check("ed_err", tx_err, 0);

        frame(8'h00, 0, 1'b0, 1'b0, bits);
        frame(8'hFF, 0, 1'b0, 1'b0, bits);
        frame(8'h01, 0, 1'b0, 1'b0, bits);
        check("01_literal", bits, 11'b1_0_00000001_0);

        frame(8'hA5, 1, 1'b0, 1'b0, bits);
        check("noack_ack", tx_ack, 0);
        check("noack_err", tx_err, 0);

        tick(3);
        send(8'h3C);
        dev_frame(2, 4, 1'b0, 1'b0, bits);
        check("to_bits", bits[4:0], {4'hC, 1'b0});
        check("to_err", tx_err, 1);
        check("to_ack", tx_ack, 0);
        check("to_idle", tx_idle, 1);
        check("to_ps2c", ps2c, 1);
        check("to_ps2d", ps2d, 1);

        tick(2);
        frame(8'h96, 0, 1'b1, 1'b1, bits);
        frame(8'h5A, 0, 1'b0, 1'b0, bits);

        tick(2);
        send(8'hC3);
        dev_frame(3, 6, 1'b0, 1'b0, bits);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_idle", tx_idle, 1);
        check("mid_rst_ps2c", ps2c, 1);
        check("mid_rst_ps2d", ps2d, 1);
        tick(2);
        frame(8'h55, 0, 1'b0, 1'b0, bits);
        check("55_literal", bits, 11'b1_1_01010101_0);

        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            tick($urandom_range(0, 3));
            frame(d, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), bits);
        end

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
